// File: rtl/cpu_run_ctrl.sv
// Run/step sequencer for the Mini-CPU.
// Produces the core's step_en pulse, either free-running from a clock divider (mode=1) or once
// per debounced press of the active-low step button (mode=0). Also latches halt requests and
// counts executed steps.
module cpu_run_ctrl #(
  parameter int unsigned DEB_CYCLES = 50000,
  parameter int unsigned RUN_DIV    = 1000000,
  parameter int unsigned CNT_W      = 24
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        mode,
  input  logic        n_step,
  input  logic        halt,
  output logic        step_en,
  output logic        running,
  output logic        halted,
  output logic [15:0] step_count
);

  localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DivLast = CNT_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {StStep, StRun, StHalted} state_e;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb_level;
  logic [CNT_W-1:0] r_deb_cnt;
  logic             r_press;

  state_e           r_state;
  state_e           w_state_d;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] w_div_d;
  logic             r_step_en;
  logic             w_step_en_d;
  logic [15:0]      r_step_count;

  // Two-flop synchronizer for the raw button; idles high (released).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= n_step;
      r_sync2 <= r_sync1;
    end
  end

  // Debouncer: accept a new level after DEB_CYCLES consecutive disagreeing cycles; a falling
  // accepted level raises a one-cycle press pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_deb_cnt   <= '0;
      r_deb_level <= 1'b1;
      r_press     <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync2 == r_deb_level) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DebLast) begin
        r_deb_cnt   <= '0;
        r_deb_level <= r_sync2;
        // Only a release->press change (level going to 0) counts as a press.
        r_press     <= ~r_sync2;
      end else begin
        r_deb_cnt <= r_deb_cnt + CNT_W'(1);
      end
    end
  end

  // Next-state, divider and step_en decode; halt overrides any press or divider wrap.
  always_comb begin
    w_state_d   = r_state;
    w_div_d     = r_div;
    w_step_en_d = 1'b0;
    unique case (r_state)
      StStep: begin
        if (halt) begin
          w_state_d = StHalted;
        end else begin
          // A press coinciding with mode=1 still steps once before entering RUN.
          if (r_press) w_step_en_d = 1'b1;
          if (mode) begin
            w_state_d = StRun;
            w_div_d   = '0;
          end
        end
      end
      StRun: begin
        if (halt) begin
          w_state_d = StHalted;
          w_div_d   = '0;
        end else if (!mode) begin
          w_state_d = StStep;
          w_div_d   = '0;
        end else if (r_div == DivLast) begin
          w_div_d     = '0;
          w_step_en_d = 1'b1;
        end else begin
          w_div_d = r_div + CNT_W'(1);
        end
      end
      StHalted: begin
        w_div_d = '0;
        // The releasing press is consumed without stepping the core.
        if (!halt && r_press) w_state_d = StStep;
      end
      default: begin
        w_state_d = StStep;
        w_div_d   = '0;
      end
    endcase
  end

  // State, divider and registered step_en.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= StStep;
      r_div     <= '0;
      r_step_en <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_div     <= w_div_d;
      r_step_en <= w_step_en_d;
    end
  end

  // Executed-step counter; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_step_count <= '0;
    end else if (r_step_en) begin
      r_step_count <= r_step_count + 16'd1;
    end
  end

  assign step_en    = r_step_en;
  assign running    = (r_state == StRun);
  assign halted     = (r_state == StHalted);
  assign step_count = r_step_count;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl (DEB_CYCLES=4, RUN_DIV=8).
// Expected step_en pulse times are queued when stimulus is applied and popped by a monitor
// whenever the DUT pulses step_en.
module tb_cpu_run_ctrl;

  logic        clk;
  logic        n_rst;
  logic        mode;
  logic        n_step;
  logic        halt;
  logic        step_en;
  logic        running;
  logic        halted;
  logic [15:0] step_count;

  typedef struct {
    int lo;
    int hi;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] exp_count;
  int          cyc;
  int          n_checks;
  int          n_fail;

  cpu_run_ctrl #(
    .DEB_CYCLES(4),
    .RUN_DIV   (8),
    .CNT_W     (8)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .mode      (mode),
    .n_step    (n_step),
    .halt      (halt),
    .step_en   (step_en),
    .running   (running),
    .halted    (halted),
    .step_count(step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: number of rising edges so far; stable when sampled on the falling edge.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_step(input int lo, input int hi);
    exp_t e;
    e.lo = lo;
    e.hi = hi;
    exp_q.push_back(e);
    exp_count = exp_count + 16'd1;
  endtask

  // Monitor: every observed pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (n_rst && step_en) begin
      if (exp_q.size() == 0) begin
        check("spurious_step", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.lo == mon_e.hi) check("step_cycle", cyc, mon_e.lo);
        else check("step_window", (cyc >= mon_e.lo && cyc <= mon_e.hi), 1);
      end
    end
  end

  initial begin
    int k;
    n_checks  = 0;
    n_fail    = 0;
    exp_count = 16'd0;
    n_rst     = 1'b0;
    mode      = 1'b0;
    n_step    = 1'b1;
    halt      = 1'b0;

    // Reset state.
    tick(3);
    check("rst_step_en", step_en, 0);
    check("rst_running", running, 0);
    check("rst_halted", halted, 0);
    check("rst_count", step_count, 0);
    n_rst = 1'b1;
    tick(3);

    // 1: clean press in single-step mode -> one pulse 6..8 cycles after the fall.
    k = cyc;
    push_step(k + 6, k + 8);
    n_step = 1'b0;
    tick(20);
    n_step = 1'b1;
    tick(12);
    check("t1_missing", exp_q.size(), 0);
    check("t1_count", step_count, exp_count);

    // 2: three 2-cycle glitches -> no pulse.
    for (int i = 0; i < 3; i++) begin
      n_step = 1'b0;
      tick(2);
      n_step = 1'b1;
      tick(4);
    end
    tick(10);
    check("t2_count", step_count, exp_count);

    // 3: free-run; mode first seen at edge k+1, pulses every 8 cycles after that.
    k = cyc;
    for (int j = 1; j <= 10; j++) push_step(k + 1 + 8 * j, k + 1 + 8 * j);
    mode = 1'b1;
    tick(40);
    check("t3_running", running, 1);
    tick(41);
    mode = 1'b0;
    tick(1);
    check("t3_stopped", running, 0);
    tick(20);
    check("t3_missing", exp_q.size(), 0);
    check("t3_count", step_count, exp_count);

    // 4: halt on the divider-wrap cycle, press while halted, then release and press.
    k = cyc;
    mode = 1'b1;
    tick(8);
    halt = 1'b1;
    tick(1);
    check("t4_halted", halted, 1);
    check("t4_running", running, 0);
    n_step = 1'b0;
    tick(10);
    n_step = 1'b1;
    tick(10);
    check("t4_still_halted", halted, 1);
    mode = 1'b0;
    halt = 1'b0;
    tick(3);
    check("t4_wait_press", halted, 1);
    n_step = 1'b0;
    tick(10);
    n_step = 1'b1;
    tick(10);
    check("t4_exit", halted, 0);
    check("t4_step_state", running, 0);
    check("t4_count", step_count, exp_count);

    // 5: counter wrap from 16'hFFFF.
    force dut.r_step_count = 16'hFFFF;
    #1;
    release dut.r_step_count;
    exp_count = 16'hFFFF;
    tick(1);
    k = cyc;
    push_step(k + 6, k + 8);
    n_step = 1'b0;
    tick(12);
    n_step = 1'b1;
    tick(12);
    check("t5_missing", exp_q.size(), 0);
    check("t5_wrap", step_count, exp_count);

    // 6: reset mid-run with the divider at 5, then restart in RUN.
    k = cyc;
    mode = 1'b1;
    tick(6);
    n_rst = 1'b0;
    #1;
    check("t6_step_en", step_en, 0);
    check("t6_running", running, 0);
    check("t6_halted", halted, 0);
    check("t6_count", step_count, 0);
    exp_count = 16'd0;
    tick(3);
    n_rst = 1'b1;
    k = cyc;
    push_step(k + 9, k + 9);
    tick(12);
    mode = 1'b0;
    tick(4);
    check("t6_missing", exp_q.size(), 0);
    check("t6_count_after", step_count, exp_count);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
